// File: rtl/watchdog_kick_ctrl.sv
// Watchdog kick initiator: issues periodic kicks while the monitored logic is alive,
// backs off during watchdog reset recovery, counts reset events and relays flag clears.
module watchdog_kick_ctrl #(
  parameter int PERIOD_W = 8,
  parameter int HOLDOFF  = 4,
  parameter int EVT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                alive,
  input  logic [PERIOD_W-1:0] kick_period,
  input  logic                clr_flag,
  input  logic                wtdg_rst_b,
  input  logic                flag,
  output logic                wtdg_rstrt,
  output logic                remove_flag,
  output logic                kick_missed,
  output logic                in_recovery,
  output logic [EVT_W-1:0]    wtdg_event_cnt
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);
  localparam logic [EVT_W-1:0]  EVT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ARMED, RECOVER} state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] period_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                arm_q;
  logic                alive_seen_q;
  logic                rst_b_q;
  logic                rstrt_q;
  logic                missed_q;
  logic                remove_q;
  logic                recov_q;
  logic [EVT_W-1:0]    evt_q;
  logic [EVT_W-1:0]    evt_d;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == EVT_MAX) ? v : v + EVT_W'(1);
  endfunction

  assign evt_d = (rst_b_q && !wtdg_rst_b) ? sat_inc(evt_q) : evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= '0;
      hold_q       <= HOLD_INIT;
      arm_q        <= 1'b0;
      alive_seen_q <= 1'b0;
      rst_b_q      <= 1'b1;
      rstrt_q      <= 1'b0;
      missed_q     <= 1'b0;
      remove_q     <= 1'b0;
      recov_q      <= 1'b0;
      evt_q        <= '0;
    end else begin
      rstrt_q  <= 1'b0;
      missed_q <= 1'b0;
      remove_q <= clr_flag & flag;
      rst_b_q  <= wtdg_rst_b;
      evt_q    <= evt_d;
      if (!enable) begin
        state_q <= IDLE;
        recov_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= ARMED;
            period_q     <= kick_period;
            arm_q        <= 1'b1;
            alive_seen_q <= 1'b0;
          end
          ARMED: begin
            if (!wtdg_rst_b) begin
              state_q <= RECOVER;
              hold_q  <= HOLD_INIT;
              recov_q <= 1'b1;
            end else if (arm_q) begin
              // First armed cycle holds the fresh period, putting the first
              // decision kick_period+2 cycles after entry.
              arm_q        <= 1'b0;
              alive_seen_q <= alive;
            end else if (period_q == '0) begin
              if (alive_seen_q || alive) rstrt_q <= 1'b1;
              else                       missed_q <= 1'b1;
              period_q     <= kick_period;
              alive_seen_q <= 1'b0;
            end else begin
              period_q <= period_q - PERIOD_W'(1);
              if (alive) alive_seen_q <= 1'b1;
            end
          end
          RECOVER: begin
            if (!wtdg_rst_b) begin
              hold_q <= HOLD_INIT;
            end else if (hold_q == '0) begin
              state_q      <= ARMED;
              period_q     <= kick_period;
              arm_q        <= 1'b1;
              alive_seen_q <= 1'b0;
              recov_q      <= 1'b0;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wtdg_rstrt     = rstrt_q;
  assign kick_missed    = missed_q;
  assign remove_flag    = remove_q;
  assign in_recovery    = recov_q;
  assign wtdg_event_cnt = evt_q;

endmodule

// File: tb/tb_watchdog_kick_ctrl.sv
// Bench for watchdog_kick_ctrl: table of flag/event vectors plus hand-built
// kick, starvation, recovery, saturation, enable-drop and reset sequences.
module tb_watchdog_kick_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, alive, clr, rstb, flg;
  logic [7:0] kp;
  logic       wtdg_rstrt, remove_flag, kick_missed, in_recovery;
  logic [3:0] wtdg_event_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rstrt;
    logic miss;
    logic rem;
    logic rec;
    int   cnt;
    logic care;
    int   tag;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic clr;
    logic flag;
    logic rstb;
    logic exp_rem;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[9];

  watchdog_kick_ctrl #(.PERIOD_W(8), .HOLDOFF(4), .EVT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(en), .alive(alive), .kick_period(kp),
    .clr_flag(clr), .wtdg_rst_b(rstb), .flag(flg),
    .wtdg_rstrt(wtdg_rstrt), .remove_flag(remove_flag), .kick_missed(kick_missed),
    .in_recovery(in_recovery), .wtdg_event_cnt(wtdg_event_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d t=%0t", name, tag, act, exp, $time);
    end
  endtask

  // Push expectation, clock once, pop and compare what the DUT produced.
  task automatic step(input logic er, input logic em, input logic erem, input logic erec,
                      input int ecnt, input logic care, input int tag);
    exp_t e;
    e.rstrt = er; e.miss = em; e.rem = erem; e.rec = erec;
    e.cnt = ecnt; e.care = care; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.care) begin
      chk("wtdg_rstrt", e.tag, int'(wtdg_rstrt), int'(e.rstrt));
      chk("kick_missed", e.tag, int'(kick_missed), int'(e.miss));
    end
    chk("remove_flag", e.tag, int'(remove_flag), int'(e.rem));
    chk("in_recovery", e.tag, int'(in_recovery), int'(e.rec));
    chk("event_cnt", e.tag, int'(wtdg_event_cnt), e.cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; alive = 1'b0; clr = 1'b0; rstb = 1'b1; flg = 1'b0; kp = 8'd3;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 900);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 901);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 2};

    do_reset();

    // Flag clear and event counting while idle
    for (int i = 0; i < 9; i++) begin
      clr = tbl[i].clr; flg = tbl[i].flag; rstb = tbl[i].rstb;
      step(1'b0, 1'b0, tbl[i].exp_rem, 1'b0, tbl[i].exp_cnt, 1'b1, 100 + i);
    end

    // Steady kicks, then starvation, then a 2-cycle watchdog reset
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      logic dec;
      en = 1'b1; kp = 8'd3;
      alive = (k <= 17);
      rstb = !(k == 31 || k == 32);
      dec = (k >= 5) && (k < 31) && (((k - 5) % 4) == 0);
      step(dec && (k <= 17), dec && (k > 17), 1'b0, (k >= 31 && k <= 36),
           (k >= 31) ? 1 : 0, 1'b1, 200 + k);
    end

    // Watchdog reset coincident with a decision; flag clear in ARMED
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      en = 1'b1; kp = 8'd3; alive = 1'b1;
      rstb = (k != 5);
      clr = (k == 2 || k == 3);
      flg = (k == 2);
      step(1'b0, 1'b0, (k == 2), (k >= 5), (k >= 5) ? 1 : 0, 1'b1, 300 + k);
    end

    // Event counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int ec;
      ec = (i + 1 > 15) ? 15 : i + 1;
      rstb = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, ec, 1'b1, 400 + 2 * i);
      rstb = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, ec, 1'b1, 401 + 2 * i);
    end

    // Enable dropped just before the first decision, then re-armed from idle
    do_reset();
    kp = 8'd3; alive = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      en = (k < 5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 500 + k);
    end
    for (int j = 0; j <= 6; j++) begin
      en = 1'b1;
      step((j == 5), 1'b0, 1'b0, 1'b0, 0, 1'b1, 520 + j);
    end

    // Reset asserted during recovery
    do_reset();
    en = 1'b1; kp = 8'd3; alive = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 600);
    rstb = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 601);
    clr = 1'b1; flg = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 602);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 603);
    rst = 1'b0; en = 1'b0; clr = 1'b0; flg = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 604);
    rstb = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 605);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
